// File: rtl/fir_decimator.sv
// fir_decimator: sums DECIM filter samples, rounds, shifts and saturates
// to 8 bits, then queues each result in a 2-entry valid/ready buffer.
module fir_decimator #(
    parameter int DECIM = 4,
    parameter int SHIFT = 11,
    parameter int ACC_W = 17 + $clog2(DECIM)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] in_data,
    input  logic        in_valid,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overrun
);

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int RND_W = (ACC_W + 1 > SHIFT + 1) ? ACC_W + 1 : SHIFT + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DECIM - 1);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] sum;
    logic [RND_W-1:0] rnd;
    logic [RND_W-1:0] r;
    logic [7:0]       result;

    logic       last;
    logic       push;
    logic       pop;
    logic       full;
    logic       accept;
    logic [7:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    assign last      = (cnt == LAST);
    assign push      = in_valid && last;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign full      = (count == 2'd2);
    assign accept    = push && (!full || pop);
    assign out_data  = mem[rd_ptr];

    // Group sum, round-half-up shift and 8-bit saturation of the result.
    always_comb begin
        sum    = acc + ACC_W'(in_data);
        rnd    = RND_W'(sum) + (RND_W'(1) << (SHIFT - 1));
        r      = rnd >> SHIFT;
        result = (r > RND_W'(255)) ? 8'hff : r[7:0];
    end

    // Accumulate valid samples; clear at group end so the next starts fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (in_valid) begin
            if (last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Output buffer: push accepted results, pop on handshake, flag drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            overrun <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= result;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (push && !accept) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_decimator.sv
// tb_fir_decimator: scoreboard bench for the DECIM=4/SHIFT=11 and the
// DECIM=1/SHIFT=9 configurations of fir_decimator.
module tb_fir_decimator;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] in_data;
    logic        in_valid;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;

    logic [16:0] in_data1;
    logic        in_valid1;
    logic [7:0]  out_data1;
    logic        out_valid1;
    logic        out_ready1;
    logic        overrun1;

    int n_tests = 0;
    int n_fail  = 0;
    int pops    = 0;
    int q  [$];
    int q1 [$];

    always #5 clk = ~clk;

    fir_decimator #(.DECIM(4), .SHIFT(11)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    fir_decimator #(.DECIM(1), .SHIFT(9)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data1),
        .in_valid  (in_valid1),
        .out_data  (out_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .overrun   (overrun1)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_result(input int sum, input int sh);
        int r;
        r = (sum + (1 << (sh - 1))) >> sh;
        return (r > 255) ? 255 : r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d);
        in_valid = 1'b1;
        in_data  = 17'(d);
        step();
        in_valid = 1'b0;
    endtask

    task automatic group(input int d);
        q.push_back(ref_result(4 * d, 11));
        for (int i = 0; i < 4; i++) drive(d);
    endtask

    // Scoreboard for the DECIM=4 instance.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                check("out_data", int'(out_data), q.pop_front());
                pops++;
            end
        end
    end

    // Scoreboard for the DECIM=1 instance.
    always @(negedge clk) begin
        if (!rst && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                check("spurious_out1", 1, 0);
            end else begin
                check("out_data1", int'(out_data1), q1.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        int gap_v [7];
        int gap_d [4];
        int k;
        gap_v = '{1, 0, 0, 1, 0, 1, 1};
        gap_d = '{1000, 2000, 3000, 4000};

        rst        = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        in_data1   = '0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        repeat (3) step();
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_valid1", int'(out_valid1), 0);
        rst = 1'b0;
        step();

        // scaling and one-cycle latency
        q.push_back(1);
        for (int i = 0; i < 4; i++) begin
            check("scale_early", int'(out_valid), 0);
            drive(512);
        end
        check("scale_latency", int'(out_valid), 1);
        step();
        check("scale_one_cycle", int'(out_valid), 0);

        // saturation then zero
        group(131071);
        group(0);
        repeat (3) step();
        check("sat_drained", q.size(), 0);

        // gapped input
        k = 0;
        for (int i = 0; i < 7; i++) begin
            check("gap_early", int'(out_valid), 0);
            if (gap_v[i] == 1) begin
                if (k == 3) q.push_back(5);
                drive(gap_d[k]);
                k++;
            end else begin
                step();
            end
        end
        check("gap_latency", int'(out_valid), 1);
        repeat (3) step();
        check("gap_drained", q.size(), 0);

        // backpressure and overrun
        out_ready = 1'b0;
        group(2048);
        group(2048);
        check("bp_overrun_pre", int'(overrun), 0);
        for (int i = 0; i < 4; i++) drive(2048);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", int'(out_valid), 1);
            check("bp_hold", int'(out_data), 4);
            step();
        end
        check("bp_overrun", int'(overrun), 1);
        pops      = 0;
        out_ready = 1'b1;
        repeat (4) step();
        check("bp_pops", pops, 2);
        check("bp_empty", int'(out_valid), 0);
        check("bp_sticky", int'(overrun), 1);

        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_clears_ovr", int'(overrun), 0);
        step();

        // full buffer with a pop on the completing cycle
        out_ready = 1'b0;
        group(512);
        group(2048);
        q.push_back(8);
        for (int i = 0; i < 3; i++) drive(4096);
        out_ready = 1'b1;
        drive(4096);
        repeat (4) step();
        check("fp_overrun", int'(overrun), 0);
        check("fp_drained", q.size(), 0);

        // reset mid-group
        drive(60000);
        drive(60000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        group(4096);
        repeat (3) step();
        check("rmg_drained", q.size(), 0);
        check("rmg_overrun", int'(overrun), 0);

        // DECIM=1 instance
        for (int i = 0; i < 3; i++) begin
            q1.push_back(2);
            in_valid1 = 1'b1;
            in_data1  = 17'd1024;
            step();
            in_valid1 = 1'b0;
            check("d1_latency", int'(out_valid1), 1);
            check("d1_data", int'(out_data1), 2);
            step();
        end
        q1.push_back(ref_result(131071, 9));
        in_valid1 = 1'b1;
        in_data1  = 17'd131071;
        step();
        in_valid1 = 1'b0;
        repeat (3) step();
        check("d1_drained", q1.size(), 0);
        check("d1_overrun", int'(overrun1), 0);
        check("final_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
